rv_commit_checker: RTL and testbench
====================================

Name: rv_commit_checker

Overview:
- Synthesizable self-checking commit monitor for the RISC-V cores (single-cycle now, pipelined later); generalises the fixed five-register bench check.
- Snoops the register-file writeback port and compares committed results against a loadable expected table of DEPTH entries.
- Two modes: ordered commit-by-commit checking, or final-state checking of a shadow register file after halt.
- Reports pass/fail, failure cause and index, and cycle and commit counts; includes a watchdog timeout.

Parameters:
- XLEN, 32, register/data width.
- DEPTH, 16, expected-table entries (power of 2); IDXW = clog2(DEPTH).
- MAX_CYCLES, 1024, watchdog limit in RUN cycles.
- CYCW, 16, cycle/commit counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- cfg_we  in  1  write expected-table entry; honoured only in IDLE/DONE.
- cfg_idx  in  IDXW  table index.
- cfg_rd  in  5  expected destination register.
- cfg_data  in  XLEN  expected value.
- start  in  1  one-cycle pulse that begins a run; ignored in RUN/CHECK.
- mode  in  1  0 = ordered, 1 = final-state; sampled at start.
- num_checks  in  IDXW+1  entries to check; sampled at start; clamped to DEPTH.
- halt  in  1  program-end indication from core (ebreak/end PC).
- wb_valid  in  1  register write committed this cycle.
- wb_rd  in  5  destination register.
- wb_data  in  XLEN  written value.
- busy  out  1  in RUN or CHECK.
- done  out  1  result valid; held until next start.
- pass  out  1  meaningful when done.
- fail_code  out  2  0 none, 1 mismatch, 2 missing commit, 3 timeout.
- fail_idx  out  IDXW  failing table index.
- fail_got  out  XLEN  observed value (0 for codes 2/3).
- fail_exp  out  XLEN  expected value (0 for code 3).
- cycle_cnt  out  CYCW  RUN cycles elapsed; saturates.
- commit_cnt  out  CYCW  rd≠0 writebacks seen; saturates.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; busy, done, pass, fail_code, fail_idx, fail_got, fail_exp, cycle_cnt and commit_cnt all 0. Table RAM contents are not cleared. Reset mid-run aborts to IDLE.
- States: IDLE, RUN, CHECK, DONE.
- IDLE/DONE + start: go to RUN; clear counters, check index, shadow regs (all 32 → 0) and the result outputs.
- Writebacks with wb_rd = 0 are ignored entirely: no count, no compare, and shadow x0 stays 0.
- RUN, every cycle: cycle_cnt += 1. When cycle_cnt = MAX_CYCLES−1 and halt = 0 → DONE, fail_code = 3, fail_idx = current index.
- RUN, ordered mode: on each rd≠0 wb_valid with idx < num_checks, compare {wb_rd, wb_data} with table[idx]:
  - Match: idx += 1.
  - Mismatch: → DONE, fail_code = 1, fail_idx = idx, fail_got = wb_data, fail_exp = table[idx].data. If rd differs but data matches, it is still a mismatch.
  - Commits after idx = num_checks are counted but not compared.
- RUN, final mode: each rd≠0 commit updates shadow[wb_rd].
- Halt in ordered mode:
  - idx = num_checks → DONE, pass = 1.
  - Otherwise → DONE, fail_code = 2, fail_idx = idx, fail_exp = table[idx].data.
- Halt in final mode: → CHECK. CHECK compares shadow[table[i].rd] with table[i].data for i = 0..num_checks−1, one entry per cycle.
  - First mismatch → DONE, fail_code = 1, with fail fields set.
  - All match → DONE, pass = 1.
  - num_checks = 0 → DONE with pass on the cycle after halt.
- Same-cycle wb_valid and halt: the commit is processed first (compare/shadow update), then halt is evaluated with the updated state.
- Same-cycle mismatch and halt, or timeout: mismatch has priority, then halt, then timeout.
- Latency: the verdict is visible (done = 1) the cycle after the deciding event in ordered mode; in final mode, halt + num_checks + 1 cycles after halt.
- done, pass and fail fields hold in DONE until start or reset; cfg_we in DONE is allowed.

Test Plan:
- Ordered pass: load {x1,5},{x2,7},{x3,12},{x4,12}, num=4; drive those commits then halt → done=1, pass=1, commit_cnt=4, fail_code=0.
- Ordered mismatch: same table, third commit {x3,11} → done next cycle, fail_code=1, fail_idx=2, fail_got=11, fail_exp=12.
- Missing/x0/simultaneous: commits x1, x0←99 (ignored), then x2 in the same cycle as halt → fail_code=2, fail_idx=2, fail_exp=12, commit_cnt=2.
- Final mode: writes x1←1, x1←5, x2←7, x3←12, x4←12 in arbitrary order, then halt → pass after 4 CHECK cycles. Repeat with x4 never written → fail_code=1, fail_idx=3, fail_got=0.
- Timeout: MAX_CYCLES=32, start, never halt → done at cycle_cnt=31, fail_code=3.
- Reset/restart: assert rst mid-RUN → all outputs 0, IDLE. Start again without reloading the table → table retained and pass on a correct replay. Start pulse during RUN is ignored.

Source files
------------

// File: rtl/rv_commit_checker.sv
// Commit monitor for the RISC-V cores. It snoops the register-file writeback
// port and checks the committed results against a loadable expected table.
// It has two modes: ordered commit-by-commit, or a final-state check of a shadow
// register file after halt. It reports a verdict, the failure detail, and
// cycle/commit counts, and it has a watchdog.
//
// state   | meaning
// IDLE    | waiting for start, table writable
// RUN     | program executing, commits being compared or shadowed
// CHECK   | final mode: walking the table against the shadow file
// DONE    | verdict held until next start, table writable
module rv_commit_checker #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 1024,
  parameter int CYCW       = 16,
  localparam int IDXW      = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_we_i,
  input  logic [IDXW-1:0] cfg_idx_i,
  input  logic [4:0]      cfg_rd_i,
  input  logic [XLEN-1:0] cfg_data_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [IDXW:0]   num_checks_i,
  input  logic            halt_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [1:0]      fail_code_o,
  output logic [IDXW-1:0] fail_idx_o,
  output logic [XLEN-1:0] fail_got_o,
  output logic [XLEN-1:0] fail_exp_o,
  output logic [CYCW-1:0] cycle_cnt_o,
  output logic [CYCW-1:0] commit_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

  localparam logic [IDXW:0]   DEPTH_W   = (IDXW + 1)'(DEPTH);
  localparam logic [IDXW:0]   IDX_ONE   = (IDXW + 1)'(1);
  localparam logic [CYCW-1:0] CNT_ONE   = CYCW'(1);
  localparam logic [CYCW-1:0] CNT_MAX   = '1;
  localparam logic [CYCW-1:0] CYC_LIMIT = CYCW'(MAX_CYCLES - 1);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_MISSING  = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [IDXW:0]   num_q, num_d;
  logic [IDXW:0]   idx_q, idx_d;
  logic            pass_q, pass_d;
  logic [1:0]      code_q, code_d;
  logic [IDXW-1:0] fidx_q, fidx_d;
  logic [XLEN-1:0] got_q, got_d;
  logic [XLEN-1:0] exp_q, exp_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic [CYCW-1:0] cmt_q, cmt_d;

  logic [4:0]      tbl_rd_q   [DEPTH];
  logic [XLEN-1:0] tbl_data_q [DEPTH];
  logic [XLEN-1:0] shadow_q   [32];

  logic            idle_like, start_go, commit, cmp_en, cmp_hit;
  logic [IDXW-1:0] idx_lo, after_lo;
  logic [IDXW:0]   idx_after;
  logic [CYCW-1:0] cyc_inc, cmt_inc;
  logic [XLEN-1:0] chk_data;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_go  = start_i && idle_like;
  // x0 writebacks are architecturally invisible, so they never count or compare
  assign commit    = wb_valid_i && (wb_rd_i != 5'd0);
  assign idx_lo    = idx_q[IDXW-1:0];
  assign cmp_en    = (state_q == S_RUN) && !mode_q && commit && (idx_q < num_q);
  assign cmp_hit   = ({wb_rd_i, wb_data_i} == {tbl_rd_q[idx_lo], tbl_data_q[idx_lo]});
  // index after this cycle's commit, so a same-cycle halt sees the update
  assign idx_after = (cmp_en && cmp_hit) ? idx_q + IDX_ONE : idx_q;
  assign after_lo  = idx_after[IDXW-1:0];
  assign cyc_inc   = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
  assign cmt_inc   = (cmt_q == CNT_MAX) ? cmt_q : cmt_q + CNT_ONE;
  assign chk_data  = shadow_q[tbl_rd_q[idx_lo]];

  // expected table: writable only while no run is in progress, never reset
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && idle_like) begin
      tbl_rd_q[cfg_idx_i]   <= cfg_rd_i;
      tbl_data_q[cfg_idx_i] <= cfg_data_i;
    end
  end

  // shadow register file: cleared at start, written by final-mode commits
  always_ff @(posedge clk_i) begin
    if (start_go) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else if ((state_q == S_RUN) && mode_q && commit) begin
      shadow_q[wb_rd_i] <= wb_data_i;
    end
  end

  // state and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      num_q   <= '0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
      code_q  <= FC_NONE;
      fidx_q  <= '0;
      got_q   <= '0;
      exp_q   <= '0;
      cyc_q   <= '0;
      cmt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      code_q  <= code_d;
      fidx_q  <= fidx_d;
      got_q   <= got_d;
      exp_q   <= exp_d;
      cyc_q   <= cyc_d;
      cmt_q   <= cmt_d;
    end
  end

  // next state and verdict; mismatch beats halt, halt beats timeout
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    code_d  = code_q;
    fidx_d  = fidx_q;
    got_d   = got_q;
    exp_d   = exp_q;
    cyc_d   = cyc_q;
    cmt_d   = cmt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          mode_d  = mode_i;
          num_d   = (num_checks_i > DEPTH_W) ? DEPTH_W : num_checks_i;
          idx_d   = '0;
          pass_d  = 1'b0;
          code_d  = FC_NONE;
          fidx_d  = '0;
          got_d   = '0;
          exp_d   = '0;
          cyc_d   = '0;
          cmt_d   = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (commit) cmt_d = cmt_inc;
        if (cmp_en && !cmp_hit) begin
          state_d = S_DONE;
          code_d  = FC_MISMATCH;
          fidx_d  = idx_lo;
          got_d   = wb_data_i;
          exp_d   = tbl_data_q[idx_lo];
        end else if (halt_i) begin
          idx_d = idx_after;
          if (mode_q) begin
            if (num_q == '0) begin
              state_d = S_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = S_CHECK;
              idx_d   = '0;
            end
          end else if (idx_after == num_q) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            code_d  = FC_MISSING;
            fidx_d  = after_lo;
            exp_d   = tbl_data_q[after_lo];
          end
        end else begin
          idx_d = idx_after;
          if (cyc_inc == CYC_LIMIT) begin
            state_d = S_DONE;
            code_d  = FC_TIMEOUT;
            fidx_d  = after_lo;
          end
        end
      end
      S_CHECK: begin
        if (chk_data != tbl_data_q[idx_lo]) begin
          state_d = S_DONE;
          code_d  = FC_MISMATCH;
          fidx_d  = idx_lo;
          got_d   = chk_data;
          exp_d   = tbl_data_q[idx_lo];
        end else if (idx_q == num_q - IDX_ONE) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = pass_q;
  assign fail_code_o  = code_q;
  assign fail_idx_o   = fidx_q;
  assign fail_got_o   = got_q;
  assign fail_exp_o   = exp_q;
  assign cycle_cnt_o  = cyc_q;
  assign commit_cnt_o = cmt_q;

endmodule

// File: tb/tb_rv_commit_checker.sv
// Bench for rv_commit_checker: directed scenarios plus randomized runs checked
// against a spec-level model of the verdict, its latency and the counters.
module tb_rv_commit_checker;

  localparam int MAXC = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [3:0]  cfg_idx_i;
  logic [4:0]  cfg_rd_i;
  logic [31:0] cfg_data_i;
  logic        start_i, mode_i;
  logic [4:0]  num_checks_i;
  logic        halt_i, wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        busy_o, done_o, pass_o;
  logic [1:0]  fail_code_o;
  logic [3:0]  fail_idx_o;
  logic [31:0] fail_got_o, fail_exp_o;
  logic [15:0] cycle_cnt_o, commit_cnt_o;

  rv_commit_checker #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(MAXC), .CYCW(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_rd_i(cfg_rd_i), .cfg_data_i(cfg_data_i), .start_i(start_i), .mode_i(mode_i),
    .num_checks_i(num_checks_i), .halt_i(halt_i), .wb_valid_i(wb_valid_i),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .fail_code_o(fail_code_o), .fail_idx_o(fail_idx_o),
    .fail_got_o(fail_got_o), .fail_exp_o(fail_exp_o), .cycle_cnt_o(cycle_cnt_o),
    .commit_cnt_o(commit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // one cycle of core activity; s = stray start pulse, w = stray table write
  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        h;
    logic        s;
    logic        w;
  } ev_t;

  // lat = clock edges from the first RUN cycle until done is seen (0 = never)
  typedef struct packed {
    logic [7:0]  lat;
    logic        pass;
    logic [1:0]  code;
    logic [3:0]  idx;
    logic [31:0] got;
    logic [31:0] expv;
    logic [15:0] cyc;
    logic [15:0] cmt;
  } res_t;

  ev_t         stim[$];
  logic [4:0]  m_rd[16];
  logic [31:0] m_data[16];
  int total = 0;
  int bad   = 0;

  function automatic ev_t mk(logic v, logic [4:0] rd, logic [31:0] d, logic h);
    ev_t e;
    e = '0;
    e.v = v; e.rd = rd; e.d = d; e.h = h;
    return e;
  endfunction

  // Verdict from the rules: walk the program cycle by cycle, track the table
  // pointer or the architectural register values, and decide on halt/timeout.
  function automatic res_t model(bit md, int num);
    res_t r;
    logic [31:0] sh[32];
    int idx, cyc, cmt, n;
    bit fin;
    ev_t e;
    r = '0; idx = 0; cyc = 0; cmt = 0; fin = 0;
    n = (num > 16) ? 16 : num;
    for (int i = 0; i < 32; i++) sh[i] = '0;
    for (int k = 0; k < 200 && !fin; k++) begin
      e = (k < stim.size()) ? stim[k] : '0;
      cyc++;
      if (e.v && e.rd != 0) begin
        cmt++;
        if (!md) begin
          if (idx < n) begin
            if (e.rd == m_rd[idx] && e.d == m_data[idx]) idx++;
            else begin
              r.code = 1; r.idx = idx[3:0]; r.got = e.d; r.expv = m_data[idx];
              r.lat = 8'(k + 1); fin = 1;
            end
          end
        end else sh[e.rd] = e.d;
      end
      if (!fin && e.h) begin
        fin = 1;
        if (!md) begin
          r.lat = 8'(k + 1);
          if (idx == n) r.pass = 1;
          else begin r.code = 2; r.idx = idx[3:0]; r.expv = m_data[idx]; end
        end else begin
          r.pass = 1; r.lat = 8'(k + 1 + n);
          for (int i = 0; i < n; i++) begin
            if (r.pass && sh[m_rd[i]] != m_data[i]) begin
              r.pass = 0; r.code = 1; r.idx = i[3:0];
              r.got = sh[m_rd[i]]; r.expv = m_data[i]; r.lat = 8'(k + 2 + i);
            end
          end
        end
      end
      if (!fin && cyc == MAXC - 1) begin
        fin = 1; r.code = 3; r.idx = idx[3:0]; r.lat = 8'(k + 1);
      end
    end
    r.cyc = 16'(cyc); r.cmt = 16'(cmt);
    return r;
  endfunction

  task automatic idle_inputs();
    cfg_we_i = 0; cfg_idx_i = 0; cfg_rd_i = 0; cfg_data_i = 0;
    start_i = 0; mode_i = 0; num_checks_i = 0;
    halt_i = 0; wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0;
  endtask

  task automatic load(input int i, input logic [4:0] rd, input logic [31:0] d);
    @(posedge clk_i); #1;
    cfg_we_i = 1; cfg_idx_i = i[3:0]; cfg_rd_i = rd; cfg_data_i = d;
    @(posedge clk_i); #1;
    cfg_we_i = 0;
    m_rd[i] = rd; m_data[i] = d;
  endtask

  task automatic load_basic();
    load(0, 5'd1, 32'd5); load(1, 5'd2, 32'd7);
    load(2, 5'd3, 32'd12); load(3, 5'd4, 32'd12);
  endtask

  // drives start then the stim queue; returns what the DUT reported
  task automatic do_run(input bit md, input int num, output res_t o);
    int edges;
    bit seen;
    ev_t e;
    @(posedge clk_i); #1;
    start_i = 1; mode_i = md; num_checks_i = 5'(num);
    @(posedge clk_i); #1;
    start_i = 0;
    edges = 0; seen = 0;
    while (!seen && edges < 200) begin
      e = (edges < stim.size()) ? stim[edges] : '0;
      wb_valid_i = e.v; wb_rd_i = e.rd; wb_data_i = e.d; halt_i = e.h;
      start_i = e.s; cfg_we_i = e.w; cfg_idx_i = 0; cfg_rd_i = 5'd31;
      cfg_data_i = 32'hdead_beef;
      @(posedge clk_i); #1;
      edges++;
      if (done_o) seen = 1;
    end
    idle_inputs();
    o.lat = seen ? 8'(edges) : 8'd0;
    o.pass = pass_o; o.code = fail_code_o; o.idx = fail_idx_o;
    o.got = fail_got_o; o.expv = fail_exp_o; o.cyc = cycle_cnt_o; o.cmt = commit_cnt_o;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({busy_o, done_o, pass_o, fail_code_o, fail_idx_o} !== 9'd0) begin
      bad++;
      $display("FAIL reset_flags: busy=%b done=%b pass=%b code=%0d idx=%0d, want all 0",
               busy_o, done_o, pass_o, fail_code_o, fail_idx_o);
    end
    total++;
    if ({fail_got_o, fail_exp_o, cycle_cnt_o, commit_cnt_o} !== 96'd0) begin
      bad++;
      $display("FAIL reset_data: got=%h exp=%h cyc=%0d cmt=%0d, want all 0",
               fail_got_o, fail_exp_o, cycle_cnt_o, commit_cnt_o);
    end
    rst_ni = 1;
  endtask

  task automatic test_ordered_pass();
    res_t o, w;
    load_basic();
    stim.delete();
    stim.push_back(mk(1, 1, 5, 0));  stim.push_back(mk(1, 2, 7, 0));
    stim.push_back(mk(1, 3, 12, 0)); stim.push_back(mk(1, 4, 12, 0));
    stim.push_back(mk(0, 0, 0, 1));
    w = model(0, 4);
    do_run(0, 4, o);
    total++;
    if (o !== w) begin
      bad++;
      $display("FAIL ordered_pass: lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cyc=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cyc=%0d cmt=%0d",
               o.lat, o.pass, o.code, o.idx, o.got, o.expv, o.cyc, o.cmt,
               w.lat, w.pass, w.code, w.idx, w.got, w.expv, w.cyc, w.cmt);
    end
    total++;
    if ({o.pass, o.code, o.cmt} !== {1'b1, 2'd0, 16'd4}) begin
      bad++;
      $display("FAIL ordered_pass_const: pass=%0d code=%0d cmt=%0d, want 1 0 4", o.pass, o.code, o.cmt);
    end
  endtask

  task automatic test_ordered_mismatch();
    res_t o, w;
    stim.delete();
    stim.push_back(mk(1, 1, 5, 0)); stim.push_back(mk(1, 2, 7, 0));
    stim.push_back(mk(1, 3, 11, 0)); stim.push_back(mk(1, 4, 12, 0));
    stim.push_back(mk(0, 0, 0, 1));
    w = model(0, 4);
    do_run(0, 4, o);
    total++;
    if (o !== w) begin
      bad++;
      $display("FAIL ordered_mismatch: lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d",
               o.lat, o.pass, o.code, o.idx, o.got, o.expv, o.cmt,
               w.lat, w.pass, w.code, w.idx, w.got, w.expv, w.cmt);
    end
    total++;
    if ({o.lat, o.code, o.idx, o.got, o.expv} !== {8'd3, 2'd1, 4'd2, 32'd11, 32'd12}) begin
      bad++;
      $display("FAIL ordered_mismatch_const: lat=%0d code=%0d idx=%0d got=%0d exp=%0d, want 3 1 2 11 12",
               o.lat, o.code, o.idx, o.got, o.expv);
    end
  endtask

  task automatic test_missing();
    res_t o, w;
    stim.delete();
    stim.push_back(mk(1, 1, 5, 0)); stim.push_back(mk(1, 0, 99, 0));
    stim.push_back(mk(1, 2, 7, 1));
    w = model(0, 4);
    do_run(0, 4, o);
    total++;
    if (o !== w) begin
      bad++;
      $display("FAIL missing: lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d",
               o.lat, o.pass, o.code, o.idx, o.got, o.expv, o.cmt,
               w.lat, w.pass, w.code, w.idx, w.got, w.expv, w.cmt);
    end
    total++;
    if ({o.code, o.idx, o.got, o.expv, o.cmt} !== {2'd2, 4'd2, 32'd0, 32'd12, 16'd2}) begin
      bad++;
      $display("FAIL missing_const: code=%0d idx=%0d got=%0d exp=%0d cmt=%0d, want 2 2 0 12 2",
               o.code, o.idx, o.got, o.expv, o.cmt);
    end
  endtask

  task automatic test_restart();
    res_t o, w;
    ev_t e;
    @(posedge clk_i); #1;
    start_i = 1; mode_i = 0; num_checks_i = 5'd4;
    @(posedge clk_i); #1;
    start_i = 0;
    total++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_in_run: busy=%b done=%b, want 1 0", busy_o, done_o);
    end
    wb_valid_i = 1; wb_rd_i = 1; wb_data_i = 5;
    @(posedge clk_i); #1;
    wb_rd_i = 2; wb_data_i = 7;
    @(posedge clk_i); #1;
    idle_inputs();
    rst_ni = 0;
    @(posedge clk_i); #1;
    rst_ni = 1;
    total++;
    if ({busy_o, done_o, pass_o, fail_code_o, cycle_cnt_o, commit_cnt_o} !== 37'd0) begin
      bad++;
      $display("FAIL midrun_reset: busy=%b done=%b pass=%b code=%0d cyc=%0d cmt=%0d, want all 0",
               busy_o, done_o, pass_o, fail_code_o, cycle_cnt_o, commit_cnt_o);
    end
    // replay without reloading; a stray start and a stray table write mid-run
    stim.delete();
    e = mk(1, 1, 5, 0); e.s = 1; stim.push_back(e);
    e = mk(1, 2, 7, 0); e.w = 1; stim.push_back(e);
    stim.push_back(mk(1, 3, 12, 0)); stim.push_back(mk(1, 4, 12, 0));
    stim.push_back(mk(0, 0, 0, 1));
    w = model(0, 4);
    do_run(0, 4, o);
    total++;
    if (o !== w || o.pass !== 1'b1) begin
      bad++;
      $display("FAIL replay: lat=%0d pass=%0d code=%0d idx=%0d cyc=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d cyc=%0d cmt=%0d",
               o.lat, o.pass, o.code, o.idx, o.cyc, o.cmt, w.lat, w.pass, w.code, w.idx, w.cyc, w.cmt);
    end
  endtask

  task automatic test_final();
    res_t o, w;
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      stim.delete();
      stim.push_back(mk(1, 1, 1, 0));  stim.push_back(mk(0, 0, 0, 0));
      stim.push_back(mk(1, 3, 12, 0)); stim.push_back(mk(1, 1, 5, 0));
      stim.push_back(mk(1, 0, 3, 0));
      stim.push_back(pass_no == 0 ? mk(1, 4, 12, 0) : mk(0, 0, 0, 0));
      stim.push_back(mk(1, 2, 7, 0));  stim.push_back(mk(0, 0, 0, 1));
      w = model(1, 4);
      do_run(1, 4, o);
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL final_%0d: lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cmt=%0d",
                 pass_no, o.lat, o.pass, o.code, o.idx, o.got, o.expv, o.cmt,
                 w.lat, w.pass, w.code, w.idx, w.got, w.expv, w.cmt);
      end
      total++;
      if (pass_no == 0 && {o.lat, o.pass} !== {8'd12, 1'b1}) begin
        bad++;
        $display("FAIL final_pass_const: lat=%0d pass=%0d, want 12 1", o.lat, o.pass);
      end else if (pass_no == 1 && {o.code, o.idx, o.got, o.expv} !== {2'd1, 4'd3, 32'd0, 32'd12}) begin
        bad++;
        $display("FAIL final_miss_const: code=%0d idx=%0d got=%0d exp=%0d, want 1 3 0 12",
                 o.code, o.idx, o.got, o.expv);
      end
    end
  endtask

  task automatic test_timeout();
    res_t o, w;
    stim.delete();
    w = model(0, 4);
    do_run(0, 4, o);
    total++;
    if (o !== w || {o.code, o.cyc, o.idx} !== {2'd3, 16'd31, 4'd0}) begin
      bad++;
      $display("FAIL timeout: lat=%0d code=%0d idx=%0d cyc=%0d, want lat=%0d code=3 idx=0 cyc=31",
               o.lat, o.code, o.idx, o.cyc, w.lat);
    end
  endtask

  task automatic test_random();
    res_t o, w;
    bit md;
    int num, n;
    for (int it = 0; it < 40; it++) begin
      md  = 1'($urandom_range(0, 1));
      num = $urandom_range(0, 20);
      n   = (num > 16) ? 16 : num;
      for (int i = 0; i < 16; i++) load(i, 5'($urandom_range(1, 31)), $urandom_range(0, 7));
      stim.delete();
      if (md) for (int j = $urandom_range(0, 3); j > 0; j--)
        stim.push_back(mk(1, 5'($urandom_range(0, 31)), $urandom_range(0, 7), 0));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) stim.push_back(mk(0, 0, 0, 0));
        if ($urandom_range(0, 7) == 0) stim.push_back(mk(1, 0, $urandom, 0));
        case ($urandom_range(0, 11))
          0:       stim.push_back(mk(0, 0, 0, 0));
          1:       stim.push_back(mk(1, m_rd[i], m_data[i] ^ 32'd1, 0));
          2:       stim.push_back(mk(1, m_rd[i] ^ 5'd1, m_data[i], 0));
          default: stim.push_back(mk(1, m_rd[i], m_data[i], 0));
        endcase
      end
      for (int j = $urandom_range(0, 2); j > 0; j--)
        stim.push_back(mk(1, 5'($urandom_range(1, 31)), $urandom_range(0, 7), 0));
      if (stim.size() > 0 && $urandom_range(0, 2) == 0) stim[stim.size() - 1].h = 1;
      else stim.push_back(mk(0, 0, 0, 1));
      w = model(md, num);
      do_run(md, num, o);
      total++;
      if (o !== w) begin
        bad++;
        $display("FAIL random_%0d mode=%0d num=%0d: lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cyc=%0d cmt=%0d, want lat=%0d pass=%0d code=%0d idx=%0d got=%0d exp=%0d cyc=%0d cmt=%0d",
                 it, md, num, o.lat, o.pass, o.code, o.idx, o.got, o.expv, o.cyc, o.cmt,
                 w.lat, w.pass, w.code, w.idx, w.got, w.expv, w.cyc, w.cmt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordered_pass();
    test_ordered_mismatch();
    test_missing();
    test_restart();
    test_final();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
